// File: rtl/decode_stage_if.sv
// Handshake and decoded-field bus between fetch, the decode stage and execute.
// The decode stage connects through the slave modport. The driver of in_* and
// consumer of out_* (fetch/execute, or a bench) connects through the master modport.
interface decode_stage_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [XLEN-1:0] in_pc;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [4:0]      out_rd;
  logic [6:0]      out_opcode;
  logic [2:0]      out_funct3;
  logic [6:0]      out_funct7;
  logic [XLEN-1:0] out_imm;
  logic            out_reg_write_en;
  logic [2:0]      out_wb_sel;
  logic            out_mem_req;
  logic            out_mem_write;
  logic            out_illegal;

  modport slave (
    input  in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd,
           out_opcode, out_funct3, out_funct7, out_imm,
           out_reg_write_en, out_wb_sel, out_mem_req, out_mem_write,
           out_illegal
  );

  modport master (
    output in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd,
           out_opcode, out_funct3, out_funct7, out_imm,
           out_reg_write_en, out_wb_sel, out_mem_req, out_mem_write,
           out_illegal
  );
endinterface

// File: rtl/decode_stage.sv
// Registered RV32I decode stage with a main slot and a skid slot, so fetch
// sees full throughput under back-pressure, plus a saturating stall counter.
// All out_* fields come straight from the main-slot register.
module decode_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  decode_stage_if.slave    bus,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYS      = 7'b1110011;

  // Writeback-select encoding shared with execute; 0 means "no writeback".
  localparam logic [2:0] WB_ALU = 3'd1;
  localparam logic [2:0] WB_MEM = 3'd2;
  localparam logic [2:0] WB_PC4 = 3'd3;
  localparam logic [2:0] WB_SYS = 3'd4;

  localparam logic MEM_REQ_READ  = 1'b0;
  localparam logic MEM_REQ_WRITE = 1'b1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic            reg_write_en;
    logic [2:0]      wb_sel;
    logic            mem_req;
    logic            mem_write;
    logic            illegal;
  } dec_t;

  dec_t            dec;
  dec_t            m_data;
  dec_t            s_data;
  logic            m_valid;
  logic            s_valid;
  logic            accept;
  logic            consume;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] imm_j;
  logic [XLEN-1:0] imm;
  logic            known;
  logic            bad;
  logic            writes;
  logic            is_mem;
  logic [2:0]      wb;

  assign opcode = bus.in_inst[6:0];
  assign funct3 = bus.in_inst[14:12];
  assign funct7 = bus.in_inst[31:25];

  // Every immediate format is sign-extended from inst[31] via a signed size cast.
  assign imm_i = XLEN'($signed(bus.in_inst[31:20]));
  assign imm_s = XLEN'($signed({bus.in_inst[31:25], bus.in_inst[11:7]}));
  assign imm_b = XLEN'($signed({bus.in_inst[31], bus.in_inst[7], bus.in_inst[30:25],
                                bus.in_inst[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({bus.in_inst[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({bus.in_inst[31], bus.in_inst[19:12], bus.in_inst[20],
                                bus.in_inst[30:21], 1'b0}));

  // Opcode classification: immediate format, writeback class and legality.
  always_comb begin
    known  = 1'b1;
    bad    = 1'b0;
    writes = 1'b0;
    is_mem = 1'b0;
    wb     = 3'd0;
    imm    = '0;
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin
        writes = 1'b1;
        wb     = WB_ALU;
        imm    = imm_u;
      end
      OPC_JAL: begin
        writes = 1'b1;
        wb     = WB_PC4;
        imm    = imm_j;
      end
      OPC_JALR: begin
        writes = 1'b1;
        wb     = WB_PC4;
        imm    = imm_i;
        bad    = (funct3 != 3'b000);
      end
      OPC_BRANCH: begin
        imm = imm_b;
        bad = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      OPC_LOAD: begin
        writes = 1'b1;
        is_mem = 1'b1;
        wb     = WB_MEM;
        imm    = imm_i;
        bad    = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OPC_STORE: begin
        is_mem = 1'b1;
        imm    = imm_s;
        bad    = (funct3 >= 3'b011);
      end
      OPC_OP_IMM: begin
        writes = 1'b1;
        wb     = WB_ALU;
        imm    = imm_i;
        if (funct3 == 3'b001)
          bad = (funct7 != 7'b0000000);
        else if (funct3 == 3'b101)
          bad = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
      end
      OPC_OP: begin
        writes = 1'b1;
        wb     = WB_ALU;
        if ((funct7 != 7'b0000000) && (funct7 != 7'b0100000))
          bad = 1'b1;
        else if ((funct7 == 7'b0100000) && (funct3 != 3'b000) && (funct3 != 3'b101))
          bad = 1'b1;
      end
      OPC_MISC_MEM: begin
      end
      OPC_SYS: begin
        writes = 1'b1;
        wb     = WB_SYS;
        imm    = imm_i;
      end
      default: known = 1'b0;
    endcase
    if (!known || (bus.in_inst[1:0] != 2'b11))
      bad = 1'b1;
  end

  // Assemble the decoded record; fields pass through even when illegal.
  always_comb begin
    dec              = '0;
    dec.pc           = bus.in_pc;
    dec.rs1          = bus.in_inst[19:15];
    dec.rs2          = bus.in_inst[24:20];
    dec.rd           = bus.in_inst[11:7];
    dec.opcode       = opcode;
    dec.funct3       = funct3;
    dec.funct7       = funct7;
    dec.imm          = imm;
    dec.illegal      = bad;
    dec.reg_write_en = writes && !bad && (bus.in_inst[11:7] != 5'd0);
    dec.wb_sel       = bad ? 3'd0 : wb;
    dec.mem_req      = is_mem && !bad;
    dec.mem_write    = (opcode == OPC_STORE) ? MEM_REQ_WRITE : MEM_REQ_READ;
  end

  assign accept  = bus.in_valid && !s_valid;
  assign consume = m_valid && bus.out_ready;

  // Two-slot FIFO: the skid slot always drains into main before newer input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
      m_data  <= '0;
      s_data  <= '0;
    end else if (flush) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (!m_valid || consume) begin
      if (s_valid) begin
        m_data  <= s_data;
        m_valid <= 1'b1;
        s_valid <= 1'b0;
      end else if (accept) begin
        m_data  <= dec;
        m_valid <= 1'b1;
      end else begin
        m_valid <= 1'b0;
      end
    end else if (accept) begin
      s_data  <= dec;
      s_valid <= 1'b1;
    end
  end

  // Count stalled output cycles, sticking at all-ones; flush leaves it alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_cnt <= '0;
    else if (m_valid && !bus.out_ready && (stall_cnt != {CNT_W{1'b1}}))
      stall_cnt <= stall_cnt + 1'b1;
  end

  assign bus.in_ready         = !s_valid;
  assign bus.out_valid        = m_valid;
  assign bus.out_pc           = m_data.pc;
  assign bus.out_rs1          = m_data.rs1;
  assign bus.out_rs2          = m_data.rs2;
  assign bus.out_rd           = m_data.rd;
  assign bus.out_opcode       = m_data.opcode;
  assign bus.out_funct3       = m_data.funct3;
  assign bus.out_funct7       = m_data.funct7;
  assign bus.out_imm          = m_data.imm;
  assign bus.out_reg_write_en = m_data.reg_write_en;
  assign bus.out_wb_sel       = m_data.wb_sel;
  assign bus.out_mem_req      = m_data.mem_req;
  assign bus.out_mem_write    = m_data.mem_write;
  assign bus.out_illegal      = m_data.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a table of decode vectors streamed at full
// rate, then hand-written back-pressure, flush, async-reset and saturation sequences.
module tb_decode_stage;

  localparam int XLEN  = 32;
  localparam int CNT_W = 8;

  localparam logic [2:0] WB_ALU = 3'd1;
  localparam logic [2:0] WB_MEM = 3'd2;
  localparam logic [2:0] WB_PC4 = 3'd3;
  localparam logic [2:0] WB_SYS = 3'd4;

  logic             clk;
  logic             reset;
  logic             flush;
  logic [CNT_W-1:0] stall_cnt;

  decode_stage_if #(.XLEN(XLEN)) bus ();

  decode_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .bus       (bus),
    .stall_cnt (stall_cnt)
  );

  typedef struct {
    logic [31:0] inst;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        rwe;
    logic [2:0]  wb;
    logic        mreq;
    logic        mwr;
    logic        ill;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs [NVEC];

  int n_cmp;
  int n_fail;

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time bound so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic v, input logic [31:0] inst,
                                input logic [31:0] pc, input logic rdy);
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_inst   = inst;
    bus.in_pc     = pc;
    bus.out_ready = rdy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    flush         = 1'b0;
    reset         = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_zero_state(input string tag);
    check_output({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    check_output({tag, "_in_ready"},  64'(bus.in_ready),  64'd1);
    check_output({tag, "_out_pc"},    64'(bus.out_pc),    64'd0);
    check_output({tag, "_out_imm"},   64'(bus.out_imm),   64'd0);
    check_output({tag, "_out_rd"},    64'(bus.out_rd),    64'd0);
    check_output({tag, "_wb_sel"},    64'(bus.out_wb_sel), 64'd0);
    check_output({tag, "_illegal"},   64'(bus.out_illegal), 64'd0);
    check_output({tag, "_stall_cnt"}, 64'(stall_cnt),     64'd0);
  endtask

  initial begin
    logic [31:0] pc;
    logic [31:0] inst;
    n_cmp  = 0;
    n_fail = 0;

    //              inst          rd  rs1 rs2 imm           rwe wb      mreq mwr ill
    vecs[0]  = '{32'h00500093,  1,  0,  5, 32'h00000005, 1, WB_ALU, 0, 0, 0};
    vecs[1]  = '{32'hFFC0A103,  2,  1, 28, 32'hFFFFFFFC, 1, WB_MEM, 1, 0, 0};
    vecs[2]  = '{32'h0020A423,  8,  1,  2, 32'h00000008, 0, 3'd0,   1, 1, 0};
    vecs[3]  = '{32'h00000000,  0,  0,  0, 32'h00000000, 0, 3'd0,   0, 0, 1};
    vecs[4]  = '{32'hFFFFFFFF, 31, 31, 31, 32'h00000000, 0, 3'd0,   0, 0, 1};
    vecs[5]  = '{32'h40001033,  0,  0,  0, 32'h00000000, 0, 3'd0,   0, 0, 1};
    vecs[6]  = '{32'h123450B7,  1,  8,  3, 32'h12345000, 1, WB_ALU, 0, 0, 0};
    vecs[7]  = '{32'hFFDFF0EF,  1, 31, 29, 32'hFFFFFFFC, 1, WB_PC4, 0, 0, 0};
    vecs[8]  = '{32'h00000863, 16,  0,  0, 32'h00000010, 0, 3'd0,   0, 0, 0};
    vecs[9]  = '{32'h00002863, 16,  0,  0, 32'h00000010, 0, 3'd0,   0, 0, 1};
    vecs[10] = '{32'h00000073,  0,  0,  0, 32'h00000000, 0, WB_SYS, 0, 0, 0};
    vecs[11] = '{32'h4030D093,  1,  1,  3, 32'h00000403, 1, WB_ALU, 0, 0, 0};
    vecs[12] = '{32'h40109093,  1,  1,  1, 32'h00000401, 0, 3'd0,   0, 0, 1};
    vecs[13] = '{32'hFFFFF117,  2, 31, 31, 32'hFFFFF000, 1, WB_ALU, 0, 0, 0};
    vecs[14] = '{32'h000080E7,  1,  1,  0, 32'h00000000, 1, WB_PC4, 0, 0, 0};
    vecs[15] = '{32'h002081B3,  3,  1,  2, 32'h00000000, 1, WB_ALU, 0, 0, 0};
    vecs[16] = '{32'h0000B003,  0,  1,  0, 32'h00000000, 0, 3'd0,   0, 0, 1};

    reset         = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_inst   = '0;
    bus.in_pc     = '0;
    bus.out_ready = 1'b0;
    #12;
    check_zero_state("reset");
    do_reset();

    // Stream the table at one per cycle with out_ready high.
    for (int i = 0; i < NVEC; i++) begin
      pc   = 32'h100 + 32'(i * 4);
      inst = vecs[i].inst;
      apply_stimulus(1'b1, inst, pc, 1'b1);
      step();
      check_output($sformatf("v%0d_valid", i),  64'(bus.out_valid),        64'd1);
      check_output($sformatf("v%0d_pc", i),     64'(bus.out_pc),           64'(pc));
      check_output($sformatf("v%0d_opcode", i), 64'(bus.out_opcode),       64'(inst[6:0]));
      check_output($sformatf("v%0d_funct3", i), 64'(bus.out_funct3),       64'(inst[14:12]));
      check_output($sformatf("v%0d_funct7", i), 64'(bus.out_funct7),       64'(inst[31:25]));
      check_output($sformatf("v%0d_rd", i),     64'(bus.out_rd),           64'(vecs[i].rd));
      check_output($sformatf("v%0d_rs1", i),    64'(bus.out_rs1),          64'(vecs[i].rs1));
      check_output($sformatf("v%0d_rs2", i),    64'(bus.out_rs2),          64'(vecs[i].rs2));
      check_output($sformatf("v%0d_imm", i),    64'(bus.out_imm),          64'(vecs[i].imm));
      check_output($sformatf("v%0d_rwe", i),    64'(bus.out_reg_write_en), 64'(vecs[i].rwe));
      check_output($sformatf("v%0d_wb", i),     64'(bus.out_wb_sel),       64'(vecs[i].wb));
      check_output($sformatf("v%0d_mreq", i),   64'(bus.out_mem_req),      64'(vecs[i].mreq));
      check_output($sformatf("v%0d_mwr", i),    64'(bus.out_mem_write),    64'(vecs[i].mwr));
      check_output($sformatf("v%0d_ill", i),    64'(bus.out_illegal),      64'(vecs[i].ill));
    end
    apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1);
    step();
    check_output("drain_valid", 64'(bus.out_valid), 64'd0);

    // Back-pressure: A held in main, B in skid, C refused, then in-order drain.
    do_reset();
    apply_stimulus(1'b1, 32'h00100093, 32'h200, 1'b0);
    step();
    check_output("bp_a_valid", 64'(bus.out_valid), 64'd1);
    check_output("bp_a_pc",    64'(bus.out_pc),    64'h200);
    apply_stimulus(1'b1, 32'h00200113, 32'h204, 1'b0);
    step();
    check_output("bp_in_ready_full", 64'(bus.in_ready), 64'd0);
    apply_stimulus(1'b1, 32'h00300193, 32'h208, 1'b0);
    step();
    step();
    check_output("bp_hold_pc",    64'(bus.out_pc),    64'h200);
    check_output("bp_hold_rd",    64'(bus.out_rd),    64'd1);
    check_output("bp_hold_ready", 64'(bus.in_ready),  64'd0);
    check_output("bp_stall_cnt",  64'(stall_cnt),     64'd3);
    apply_stimulus(1'b1, 32'h00300193, 32'h208, 1'b1);
    step();
    check_output("bp_b_valid", 64'(bus.out_valid), 64'd1);
    check_output("bp_b_pc",    64'(bus.out_pc),    64'h204);
    check_output("bp_b_rd",    64'(bus.out_rd),    64'd2);
    check_output("bp_b_ready", 64'(bus.in_ready),  64'd1);
    check_output("bp_stall_hold", 64'(stall_cnt),  64'd3);
    step();
    check_output("bp_c_valid", 64'(bus.out_valid), 64'd1);
    check_output("bp_c_pc",    64'(bus.out_pc),    64'h208);
    check_output("bp_c_rd",    64'(bus.out_rd),    64'd3);
    apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1);
    step();
    check_output("bp_end_valid", 64'(bus.out_valid), 64'd0);

    // Flush with both slots full and a third input presented.
    do_reset();
    apply_stimulus(1'b1, 32'h00100093, 32'h300, 1'b0);
    step();
    apply_stimulus(1'b1, 32'h00200113, 32'h304, 1'b0);
    step();
    apply_stimulus(1'b1, 32'h00300193, 32'h308, 1'b0);
    flush = 1'b1;
    step();
    check_output("fl_valid", 64'(bus.out_valid), 64'd0);
    check_output("fl_ready", 64'(bus.in_ready),  64'd1);
    apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1);
    flush = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check_output($sformatf("fl_quiet%0d", k), 64'(bus.out_valid), 64'd0);
    end

    // Flush discards an input accepted in the same cycle.
    apply_stimulus(1'b1, 32'h00100093, 32'h400, 1'b0);
    step();
    apply_stimulus(1'b1, 32'h00200113, 32'h404, 1'b0);
    flush = 1'b1;
    step();
    check_output("fl2_valid", 64'(bus.out_valid), 64'd0);
    apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1);
    flush = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      check_output($sformatf("fl2_quiet%0d", k), 64'(bus.out_valid), 64'd0);
    end

    // Async reset between edges while stalled with a nonzero counter.
    do_reset();
    apply_stimulus(1'b1, 32'hFFC0A103, 32'h500, 1'b0);
    step();
    apply_stimulus(1'b0, 32'h0, 32'h0, 1'b0);
    step();
    step();
    check_output("ar_pre_stall", 64'(stall_cnt), 64'd2);
    #2;
    reset = 1'b1;
    #1;
    check_zero_state("async");
    do_reset();

    // Counter saturation with flush afterwards leaving it untouched.
    apply_stimulus(1'b1, 32'h00100093, 32'h600, 1'b0);
    step();
    apply_stimulus(1'b0, 32'h0, 32'h0, 1'b0);
    for (int k = 0; k < (1 << CNT_W) + 5; k++)
      step();
    check_output("sat_stall", 64'(stall_cnt), 64'((1 << CNT_W) - 1));
    @(negedge clk);
    flush = 1'b1;
    step();
    @(negedge clk);
    flush = 1'b0;
    check_output("sat_after_flush", 64'(stall_cnt), 64'((1 << CNT_W) - 1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
